// File: rtl/elbeth_lsu.sv
// ELBETH load/store unit: turns core byte-addressed loads/stores into one
// word-addressed, byte-strobed memory access and returns extended load data.
module elbeth_lsu #(
    parameter int AW      = 8,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          lsu_req,
    input  logic [31:0]   lsu_addr,
    input  logic          lsu_we,
    input  logic [1:0]    lsu_size,
    input  logic          lsu_unsigned,
    input  logic [31:0]   lsu_wdata,
    output logic [31:0]   lsu_rdata,
    output logic          lsu_done,
    output logic          lsu_busy,
    output logic          lsu_fault,
    output logic          lsu_error,
    output logic          mem_enable,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_rw,
    input  logic [31:0]   mem_rdata,
    input  logic          mem_ready
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;

    logic [2:0] state;
    logic [7:0] cnt;
    logic       err_q;
    logic       we_q;
    logic       uns_q;
    logic [1:0] size_q;
    logic [1:0] off_q;

    // Address bits above the word window are deliberately ignored (wrap).
    logic unused_addr_hi;
    assign unused_addr_hi = ^lsu_addr[31:AW+2];

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        misaligned = (size == 2'b11) ||
                     (size == 2'b01 && off[0]) ||
                     (size == 2'b10 && off != 2'b00);
    endfunction

    function automatic logic [3:0] strobes(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   strobes = 4'b0001 << off;
            2'b01:   strobes = 4'b0011 << off;
            default: strobes = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            2'b00:   replicate = {4{wdata[7:0]}};
            2'b01:   replicate = {2{wdata[15:0]}};
            default: replicate = wdata;
        endcase
    endfunction

    function automatic logic [31:0] extract(input logic [1:0] size, input logic [1:0] off,
                                            input logic uns, input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[8*off +: 8];
        h = rdata[16*off[1] +: 16];
        case (size)
            2'b00:   extract = {{24{b[7] & ~uns}}, b};
            2'b01:   extract = {{16{h[15] & ~uns}}, h};
            default: extract = rdata;
        endcase
    endfunction

    // Request attributes are pure data; they are only consulted after a capture.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && lsu_req) begin
            we_q   <= lsu_we;
            uns_q  <= lsu_unsigned;
            size_q <= lsu_size;
            off_q  <= lsu_addr[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            err_q      <= 1'b0;
            lsu_rdata  <= '0;
            mem_enable <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_rw     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    err_q <= 1'b0;
                    if (lsu_req) begin
                        if (misaligned(lsu_size, lsu_addr[1:0])) begin
                            state <= S_FAULT;
                        end else begin
                            state      <= S_ISSUE;
                            mem_enable <= 1'b1;
                            mem_addr   <= lsu_addr[AW+1:2];
                            mem_wdata  <= replicate(lsu_size, lsu_wdata);
                            mem_rw     <= lsu_we ? strobes(lsu_size, lsu_addr[1:0]) : 4'b0000;
                        end
                    end
                end
                S_ISSUE: begin
                    // Drop enable and strobes so the write is not repeated while waiting.
                    mem_enable <= 1'b0;
                    mem_rw     <= 4'b0000;
                    cnt        <= '0;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    if (mem_ready) begin
                        if (!we_q)
                            lsu_rdata <= extract(size_q, off_q, uns_q, mem_rdata);
                        state <= S_DONE;
                    end else if (cnt == 8'(TIMEOUT - 1)) begin
                        err_q <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_DONE, S_FAULT: begin
                    err_q <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign lsu_busy  = (state != S_IDLE);
    assign lsu_done  = (state == S_DONE) || (state == S_FAULT);
    assign lsu_fault = (state == S_FAULT);
    assign lsu_error = (state == S_DONE) && err_q;

endmodule

// File: tb/tb_elbeth_lsu.sv
// Self-checking bench for elbeth_lsu: registered-RAM memory model plus a
// byte-level reference model of memory contents and load results.
module tb_elbeth_lsu;
    localparam int AW = 8;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          lsu_req;
    logic [31:0]   lsu_addr;
    logic          lsu_we;
    logic [1:0]    lsu_size;
    logic          lsu_unsigned;
    logic [31:0]   lsu_wdata;
    logic [31:0]   lsu_rdata;
    logic          lsu_done;
    logic          lsu_busy;
    logic          lsu_fault;
    logic          lsu_error;
    logic          mem_enable;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_rw;
    logic [31:0]   mem_rdata;
    logic          mem_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    elbeth_lsu #(.AW(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .lsu_req(lsu_req), .lsu_addr(lsu_addr), .lsu_we(lsu_we),
        .lsu_size(lsu_size), .lsu_unsigned(lsu_unsigned), .lsu_wdata(lsu_wdata),
        .lsu_rdata(lsu_rdata), .lsu_done(lsu_done), .lsu_busy(lsu_busy),
        .lsu_fault(lsu_fault), .lsu_error(lsu_error), .mem_enable(mem_enable),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rw(mem_rw),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    // Standard memory: one-cycle registered read, ready is enable delayed.
    logic [31:0] ram [256] = '{default: '0};
    logic [31:0] rd_r    = '0;
    logic        ready_r = 1'b0;
    logic        kill    = 1'b0;
    logic [31:0] wword;
    always @(posedge clk) begin
        if (mem_enable) begin
            wword = ram[mem_addr];
            for (int i = 0; i < 4; i++)
                if (mem_rw[i]) wword[8*i +: 8] = mem_wdata[8*i +: 8];
            ram[mem_addr] <= wword;
            rd_r <= ram[mem_addr];
        end
        ready_r <= mem_enable && !kill;
    end
    assign mem_ready = ready_r;
    assign mem_rdata = ready_r ? rd_r : 32'hzzzz_zzzz;

    // Reference model: flat byte memory over the 2^AW-word window.
    logic [7:0]    refm [1024] = '{default: '0};
    logic          e_fault;
    int            e_lat;
    int            e_en;
    logic [3:0]    e_rw;
    logic [AW-1:0] e_addr;
    logic [31:0]   e_wd;
    logic [31:0]   e_rd = '0;

    task automatic model_op(input logic we, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        int base;
        logic [31:0] val;
        n = (size == 2'b11) ? 4 : (1 << size);
        e_fault = (size == 2'b11) || ((int'(addr[1:0]) % n) != 0);
        e_lat = e_fault ? 1 : 3;
        e_en  = e_fault ? 0 : 1;
        e_rw  = 4'b0000;
        e_addr = addr[AW+1:2];
        for (int k = 0; k < 4; k++) e_wd[8*k +: 8] = wdata[8*(k % n) +: 8];
        if (!e_fault) begin
            base = int'(addr[9:0]);
            if (we) begin
                for (int k = 0; k < n; k++) begin
                    e_rw[(base % 4) + k] = 1'b1;
                    refm[base + k] = wdata[8*k +: 8];
                end
            end else begin
                val = '0;
                for (int k = 0; k < n; k++) val = val | (32'(refm[base + k]) << (8*k));
                if (!uns && n < 4 && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8*n));
                e_rd = val;
            end
        end
    endtask

    int            r_lat;
    int            r_en;
    logic          r_fault;
    logic          r_err;
    logic [31:0]   r_rd;
    logic [3:0]    r_rw;
    logic [AW-1:0] r_addr;
    logic [31:0]   r_wd;

    // Issues one request and observes it to completion; returns in the first idle cycle.
    task automatic run_op(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        lsu_req = 1'b1; lsu_we = we; lsu_size = size; lsu_unsigned = uns;
        lsu_addr = addr; lsu_wdata = wdata;
        @(posedge clk); #1;
        lsu_req = 1'b0;
        r_lat = -1; r_en = 0; r_fault = 1'b0; r_err = 1'b0;
        r_rw = '0; r_addr = '0; r_wd = '0; r_rd = lsu_rdata;
        for (int c = 1; c <= 40 && r_lat < 0; c++) begin
            if (mem_enable) begin
                r_en++; r_rw = mem_rw; r_addr = mem_addr; r_wd = mem_wdata;
            end
            if (lsu_done) begin
                r_lat = c; r_fault = lsu_fault; r_err = lsu_error; r_rd = lsu_rdata;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({lsu_rdata, lsu_done, lsu_busy, lsu_fault, lsu_error, mem_enable} !== 37'd0 ||
            mem_addr !== '0 || mem_wdata !== 32'd0 || mem_rw !== 4'd0) begin
            errors++;
            $display("FAIL reset_outputs rdata=%h done=%b busy=%b maddr=%h mwd=%h rw=%b want all 0",
                     lsu_rdata, lsu_done, lsu_busy, mem_addr, mem_wdata, mem_rw);
        end
    endtask

    task automatic test_word_store_load();
        model_op(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        run_op(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        checks++;
        if (r_addr !== 8'd4 || r_rw !== 4'b1111 || r_wd !== 32'hDEADBEEF || r_lat !== 3) begin
            errors++;
            $display("FAIL word_store addr=%h rw=%b wd=%h lat=%0d want 04 1111 deadbeef 3",
                     r_addr, r_rw, r_wd, r_lat);
        end
        model_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        run_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        checks++;
        if (r_rd !== 32'hDEADBEEF || r_lat !== 3 || r_rw !== 4'b0000 || r_err !== 1'b0) begin
            errors++;
            $display("FAIL word_load rd=%h lat=%0d rw=%b err=%b want deadbeef 3 0000 0",
                     r_rd, r_lat, r_rw, r_err);
        end
    endtask

    task automatic test_byte();
        model_op(1'b1, 2'b00, 1'b0, 32'h13, 32'h000000A5);
        run_op(1'b1, 2'b00, 1'b0, 32'h13, 32'h000000A5);
        checks++;
        if (r_rw !== 4'b1000 || r_wd !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL byte_store rw=%b wd=%h want 1000 a5a5a5a5", r_rw, r_wd);
        end
        model_op(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
        run_op(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
        checks++;
        if (r_rd !== 32'hFFFFFFA5) begin
            errors++;
            $display("FAIL byte_load_signed rd=%h want ffffffa5", r_rd);
        end
        model_op(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
        run_op(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
        checks++;
        if (r_rd !== 32'h000000A5) begin
            errors++;
            $display("FAIL byte_load_unsigned rd=%h want 000000a5", r_rd);
        end
    endtask

    task automatic test_half();
        model_op(1'b1, 2'b10, 1'b0, 32'h10, 32'h80017FFF);
        run_op(1'b1, 2'b10, 1'b0, 32'h10, 32'h80017FFF);
        model_op(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
        run_op(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
        checks++;
        if (r_rd !== 32'hFFFF8001) begin
            errors++;
            $display("FAIL half_load_hi rd=%h want ffff8001", r_rd);
        end
        model_op(1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
        run_op(1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
        checks++;
        if (r_rd !== 32'h00007FFF) begin
            errors++;
            $display("FAIL half_load_lo rd=%h want 00007fff", r_rd);
        end
    endtask

    task automatic test_faults();
        logic [31:0] fa [3] = '{32'h11, 32'h01, 32'h00};
        logic [1:0]  fs [3] = '{2'b10, 2'b01, 2'b11};
        for (int i = 0; i < 3; i++) begin
            run_op(1'b0, fs[i], 1'b0, fa[i], 32'h0);
            checks++;
            if (r_lat !== 1 || r_fault !== 1'b1 || r_err !== 1'b0 || r_en !== 0 ||
                r_rd !== 32'h00007FFF) begin
                errors++;
                $display("FAIL fault_%0d lat=%0d fault=%b err=%b en=%0d rd=%h want 1 1 0 0 00007fff",
                         i, r_lat, r_fault, r_err, r_en, r_rd);
            end
        end
    endtask

    task automatic test_timeout();
        kill = 1'b1;
        run_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        checks++;
        if (r_lat !== TO + 2 || r_err !== 1'b1 || r_fault !== 1'b0 || r_en !== 1 ||
            r_rd !== e_rd) begin
            errors++;
            $display("FAIL timeout lat=%0d err=%b fault=%b en=%0d rd=%h want %0d 1 0 1 %h",
                     r_lat, r_err, r_fault, r_en, r_rd, TO + 2, e_rd);
        end
        checks++;
        if (lsu_busy !== 1'b0 || lsu_done !== 1'b0 || lsu_error !== 1'b0) begin
            errors++;
            $display("FAIL timeout_idle busy=%b done=%b err=%b want 0 0 0",
                     lsu_busy, lsu_done, lsu_error);
        end
        kill = 1'b0;
    endtask

    task automatic test_reset_in_wait();
        int dones = 0;
        kill = 1'b1;
        @(negedge clk);
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_size = 2'b10; lsu_addr = 32'h10;
        @(posedge clk); #1 lsu_req = 1'b0;
        @(posedge clk); #1;
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (lsu_rdata !== 32'd0 || lsu_busy !== 1'b0 || lsu_done !== 1'b0 ||
            mem_addr !== '0 || mem_wdata !== 32'd0 || mem_rw !== 4'd0 || mem_enable !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_wait rdata=%h busy=%b done=%b maddr=%h mwd=%h want all 0",
                     lsu_rdata, lsu_busy, lsu_done, mem_addr, mem_wdata);
        end
        e_rd = '0;
        @(negedge clk) rst = 1'b0;
        for (int c = 0; c < TO + 6; c++) begin
            @(posedge clk); #1;
            if (lsu_done) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL reset_no_done dones=%0d want 0", dones);
        end
        kill = 1'b0;
    endtask

    task automatic test_ignored_req();
        int ens = 0;
        int dones = 0;
        model_op(1'b1, 2'b10, 1'b0, 32'h20, 32'h12345678);
        @(negedge clk);
        lsu_req = 1'b1; lsu_we = 1'b1; lsu_size = 2'b10; lsu_addr = 32'h20; lsu_wdata = 32'h12345678;
        @(posedge clk); #1;
        lsu_addr = 32'h24; lsu_wdata = 32'hCAFEF00D;
        for (int c = 1; c <= 8; c++) begin
            if (mem_enable) ens++;
            if (lsu_done) dones++;
            if (c == 3) lsu_req = 1'b0;
            @(posedge clk); #1;
        end
        checks++;
        if (ens !== 1 || dones !== 1) begin
            errors++;
            $display("FAIL ignored_req enables=%0d dones=%0d want 1 1", ens, dones);
        end
        model_op(1'b0, 2'b10, 1'b0, 32'h24, 32'h0);
        run_op(1'b0, 2'b10, 1'b0, 32'h24, 32'h0);
        checks++;
        if (r_rd !== e_rd) begin
            errors++;
            $display("FAIL ignored_req_mem rd=%h want %h", r_rd, e_rd);
        end
    endtask

    task automatic test_back_to_back();
        model_op(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        run_op(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        checks++;
        if (lsu_busy !== 1'b0 || lsu_done !== 1'b0 || r_rd !== e_rd) begin
            errors++;
            $display("FAIL b2b_first busy=%b done=%b rd=%h want 0 0 %h", lsu_busy, lsu_done, r_rd, e_rd);
        end
        model_op(1'b0, 2'b01, 1'b1, 32'h22, 32'h0);
        run_op(1'b0, 2'b01, 1'b1, 32'h22, 32'h0);
        checks++;
        if (r_lat !== 3 || r_rd !== e_rd) begin
            errors++;
            $display("FAIL b2b_second lat=%0d rd=%h want 3 %h", r_lat, r_rd, e_rd);
        end
    endtask

    task automatic test_random();
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        for (int i = 0; i < 80; i++) begin
            we    = 1'($urandom_range(0, 1));
            size  = 2'($urandom_range(0, 3));
            uns   = 1'($urandom_range(0, 1));
            addr  = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
            wdata = $urandom;
            model_op(we, size, uns, addr, wdata);
            run_op(we, size, uns, addr, wdata);
            checks++;
            if (r_lat !== e_lat || r_fault !== e_fault || r_err !== 1'b0 || r_en !== e_en ||
                r_rd !== e_rd) begin
                errors++;
                $display("FAIL rand_%0d a=%h sz=%0d we=%b lat=%0d flt=%b err=%b en=%0d rd=%h want %0d %b 0 %0d %h",
                         i, addr, size, we, r_lat, r_fault, r_err, r_en, r_rd, e_lat, e_fault, e_en, e_rd);
            end
            if (!e_fault) begin
                checks++;
                if (r_rw !== e_rw || r_addr !== e_addr || (we && r_wd !== e_wd)) begin
                    errors++;
                    $display("FAIL rand_mem_%0d rw=%b addr=%h wd=%h want %b %h %h",
                             i, r_rw, r_addr, r_wd, e_rw, e_addr, e_wd);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; lsu_req = 1'b0; lsu_addr = '0; lsu_we = 1'b0; lsu_size = '0;
        lsu_unsigned = 1'b0; lsu_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk) rst = 1'b0;
        test_word_store_load();
        test_byte();
        test_half();
        test_faults();
        test_timeout();
        test_ignored_req();
        test_back_to_back();
        test_reset_in_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
